// File: rtl/gate_truth_checker.sv
// Self-test sequencer for a 2-input NAND gate: walks a/b through 00,01,10,11 and checks y.
// Optional per-vector error log enabled by defining GATE_CHECK_ERRLOG_EN.
module gate_truth_checker #(
    parameter int unsigned SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       y,
    output logic       a,
    output logic       b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_vec
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned VEC_W = 2;
    localparam int unsigned NVEC  = 4;

    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

    state_t             state_q, state_d;
    logic [VEC_W-1:0]   vec_q, vec_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               pass_q, pass_d;
    logic               a_q, a_d, b_q, b_d;
    logic               busy_q, busy_d, done_q, done_d;
    logic               drive_c;
    logic               mism_c;

`ifdef GATE_CHECK_ERRLOG_EN
    logic [NVEC-1:0]    err_q, err_d;
`else
    logic               err_q, err_d;
`endif

    // Only an exact 0/1 match counts; X or Z on y is a mismatch.
    assign mism_c = !(y === ~(a_q & b_q));

    // Next-state and registered-output decode.
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        pass_d  = pass_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = DRIVE;
                    vec_d   = '0;
                    cnt_d   = '0;
                    pass_d  = 1'b0;
                    err_d   = '0;
                end
            end
            DRIVE: begin
                if (cnt_q == CNT_W'(SETTLE - 1)) begin
                    cnt_d   = '0;
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SAMPLE: begin
                if (mism_c) begin
`ifdef GATE_CHECK_ERRLOG_EN
                    err_d[vec_q] = 1'b1;
`else
                    err_d = 1'b1;
`endif
                end
                if (vec_q == VEC_W'(NVEC - 1)) begin
                    state_d = DONE;
                    pass_d  = ~|err_d;
                end else begin
                    vec_d   = vec_q + VEC_W'(1);
                    state_d = DRIVE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        drive_c = (state_d == DRIVE) || (state_d == SAMPLE);
        a_d     = drive_c & vec_d[1];
        b_d     = drive_c & vec_d[0];
        busy_d  = drive_c;
        done_d  = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vec_q   <= '0;
            cnt_q   <= '0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            a_q     <= a_d;
            b_q     <= b_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign a    = a_q;
    assign b    = b_q;
    assign busy = busy_q;
    assign done = done_q;
    assign pass = pass_q;

`ifdef GATE_CHECK_ERRLOG_EN
    assign err_vec = err_q;
`else
    assign err_vec = 4'b0000;
`endif

endmodule

// File: tb/tb_gate_truth_checker.sv
// Directed bench for gate_truth_checker: NAND model variants, busy-start, mid-run reset, back-to-back.
module tb_gate_truth_checker;

    logic       clk;
    logic       rst_n;
    logic       start, start2;
    logic       y, y2;
    logic       a, b, busy, done, pass;
    logic       a2, b2, busy2, done2, pass2;
    logic [3:0] err_vec, err_vec2;

    int tests;
    int fails;
    int mode;       // 0 good NAND, 1 stuck at 1, 2 stuck at 0
    int hammer;     // hold start high while a run is in progress

    int         obs_busy;
    int         obs_done;
    logic       obs_pass;
    logic [3:0] obs_err;
    logic [1:0] obs_ab [0:15];

`ifdef GATE_CHECK_ERRLOG_EN
    localparam logic [3:0] EXP_S1 = 4'b1000;
    localparam logic [3:0] EXP_S0 = 4'b0111;
`else
    localparam logic [3:0] EXP_S1 = 4'b0000;
    localparam logic [3:0] EXP_S0 = 4'b0000;
`endif

    gate_truth_checker #(.SETTLE(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .y(y),
        .a(a), .b(b), .busy(busy), .done(done), .pass(pass), .err_vec(err_vec)
    );

    gate_truth_checker #(.SETTLE(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .y(y2),
        .a(a2), .b(b2), .busy(busy2), .done(done2), .pass(pass2), .err_vec(err_vec2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        case (mode)
            1:       y = 1'b1;
            2:       y = 1'b0;
            default: y = ~(a & b);
        endcase
    end
    assign y2 = ~(a2 & b2);

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    // Observe a run from its first busy cycle until done (bounded); no checking here.
    task automatic observe_run();
        obs_busy = 0;
        obs_done = 0;
        obs_pass = 1'b0;
        obs_err  = '0;
        for (int n = 0; n < 60; n++) begin
            if (busy) begin
                if (obs_busy < 16) obs_ab[obs_busy] = {a, b};
                obs_busy++;
            end
            if (done) begin
                obs_done++;
                obs_pass = pass;
                obs_err  = err_vec;
                start    = 1'b0;
                break;
            end
            start = (hammer != 0) ? 1'b1 : 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; start2 = 1'b0; mode = 0; hammer = 0;
        repeat (2) @(negedge clk);
        tests++;
        if ({a, b, busy, done, pass, err_vec} !== 9'b0) begin
            fails++;
            $display("FAIL reset_outputs: got %b want 000000000", {a, b, busy, done, pass, err_vec});
        end
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_pass();
        mode = 0;
        pulse_start();
        observe_run();
        tests++;
        if (obs_busy != 12) begin
            fails++;
            $display("FAIL pass_busy_len: got %0d want 12", obs_busy);
        end
        for (int i = 0; i < 12; i++) begin
            tests++;
            if (obs_ab[i] !== 2'(i / 3)) begin
                fails++;
                $display("FAIL pass_ab[%0d]: got %b want %b", i, obs_ab[i], 2'(i / 3));
            end
        end
        tests++;
        if (obs_done != 1 || obs_pass !== 1'b1 || obs_err !== 4'b0000) begin
            fails++;
            $display("FAIL pass_result: done=%0d pass=%b err=%b want done=1 pass=1 err=0000",
                     obs_done, obs_pass, obs_err);
        end
        repeat (3) @(negedge clk);
        tests++;
        if (done !== 1'b0 || busy !== 1'b0 || pass !== 1'b1 || {a, b} !== 2'b00) begin
            fails++;
            $display("FAIL pass_hold: done=%b busy=%b pass=%b ab=%b want 0 0 1 00", done, busy, pass, {a, b});
        end
    endtask

    task automatic test_stuck1();
        mode = 1;
        pulse_start();
        tests++;
        if (pass !== 1'b0) begin
            fails++;
            $display("FAIL stuck1_pass_cleared: got %b want 0", pass);
        end
        observe_run();
        tests++;
        if (obs_done != 1 || obs_pass !== 1'b0 || obs_err !== EXP_S1) begin
            fails++;
            $display("FAIL stuck1_result: done=%0d pass=%b err=%b want done=1 pass=0 err=%b",
                     obs_done, obs_pass, obs_err, EXP_S1);
        end
        repeat (2) @(negedge clk);
        tests++;
        if (pass !== 1'b0 || err_vec !== EXP_S1) begin
            fails++;
            $display("FAIL stuck1_hold: pass=%b err=%b want 0 %b", pass, err_vec, EXP_S1);
        end
    endtask

    task automatic test_stuck0();
        mode = 2;
        pulse_start();
        observe_run();
        tests++;
        if (obs_done != 1 || obs_busy != 12 || obs_pass !== 1'b0 || obs_err !== EXP_S0) begin
            fails++;
            $display("FAIL stuck0_result: done=%0d busy=%0d pass=%b err=%b want 1 12 0 %b",
                     obs_done, obs_busy, obs_pass, obs_err, EXP_S0);
        end
        mode = 0;
    endtask

    task automatic test_start_while_busy();
        int extra;
        mode = 0;
        hammer = 1;
        pulse_start();
        observe_run();
        hammer = 0;
        tests++;
        if (obs_busy != 12 || obs_done != 1 || obs_pass !== 1'b1) begin
            fails++;
            $display("FAIL busy_start_run: busy=%0d done=%0d pass=%b want 12 1 1", obs_busy, obs_done, obs_pass);
        end
        extra = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (busy || done) extra++;
        end
        tests++;
        if (extra != 0) begin
            fails++;
            $display("FAIL busy_start_queued: got %0d active cycles want 0", extra);
        end
    endtask

    task automatic test_reset_mid();
        int dcount;
        mode = 0;
        pulse_start();
        repeat (7) @(negedge clk);
        tests++;
        if ({busy, a, b} !== 3'b110) begin
            fails++;
            $display("FAIL rst_mid_vec2: got busy,a,b=%b want 110", {busy, a, b});
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({a, b, busy, done, pass, err_vec} !== 9'b0) begin
            fails++;
            $display("FAIL rst_mid_async: got %b want 000000000", {a, b, busy, done, pass, err_vec});
        end
        dcount = 0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            if (done) dcount++;
        end
        rst_n = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            if (done || busy) dcount++;
        end
        tests++;
        if (dcount != 0) begin
            fails++;
            $display("FAIL rst_mid_no_done: got %0d active cycles want 0", dcount);
        end
        pulse_start();
        observe_run();
        tests++;
        if (obs_busy != 12 || obs_done != 1 || obs_pass !== 1'b1 || obs_err !== 4'b0000) begin
            fails++;
            $display("FAIL rst_mid_rerun: busy=%0d done=%0d pass=%b err=%b want 12 1 1 0000",
                     obs_busy, obs_done, obs_pass, obs_err);
        end
    endtask

    task automatic test_back_to_back();
        int ndone;
        int nbusy;
        @(negedge clk) start2 = 1'b1;
        ndone = 0;
        nbusy = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (busy2) nbusy++;
            if (done2) begin
                tests++;
                if (k != 9 + 10 * ndone || pass2 !== 1'b1) begin
                    fails++;
                    $display("FAIL b2b_done%0d: cycle=%0d pass=%b want cycle=%0d pass=1",
                             ndone, k, pass2, 9 + 10 * ndone);
                end
                ndone++;
            end
        end
        start2 = 1'b0;
        tests++;
        if (ndone != 4 || nbusy != 32) begin
            fails++;
            $display("FAIL b2b_totals: dones=%0d busy=%0d want 4 32", ndone, nbusy);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_pass();
        test_stuck1();
        test_stuck0();
        test_start_while_busy();
        test_reset_mid();
        test_back_to_back();
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/gate_truth_checker.md
GATE_TRUTH_CHECKER -- requirements
Module: gate_truth_checker

Interface
REQ-001 SHALL have parameter SETTLE, default 2: cycles the gate inputs are held before y is sampled; legal range 1..15.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: request one check run.
REQ-005 SHALL have port y, input, 1 bit: output of the 2-input NAND gate under test.
REQ-006 SHALL have port a, output, 1 bit: first gate input, registered.
REQ-007 SHALL have port b, output, 1 bit: second gate input, registered.
REQ-008 SHALL have port busy, output, 1 bit: high while a run is in progress.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse at the end of a run.
REQ-010 SHALL have port pass, output, 1 bit: result of the last completed run, 1 means all four vectors matched.
REQ-011 SHALL have port err_vec, output, 4 bits: per-vector mismatch flags, bit i for vector i.

Function
REQ-012 SHALL implement FSM states IDLE, DRIVE, SAMPLE and DONE.
REQ-013 SHALL transition IDLE->DRIVE on a clock edge where start=1, clearing the 2-bit vector index to 0, the mismatch flags and pass.
REQ-014 SHALL ignore start in every state other than IDLE; no queuing.
REQ-015 SHALL drive a=vec[1] and b=vec[0] in DRIVE and SAMPLE, and drive a=b=0 in IDLE and DONE.
REQ-016 SHALL hold DRIVE for exactly SETTLE cycles via a 4-bit settle counter, then go to SAMPLE.
REQ-017 SHALL, in SAMPLE (one cycle), compare y to the expected value ~(a&b) and set the mismatch flag for the current index on inequality.
REQ-018 SHALL, from SAMPLE, increment the index and return to DRIVE if the index is below 3, else go to DONE.
REQ-019 SHALL keep each vector active for SETTLE+1 cycles, so busy is high for exactly 4*(SETTLE+1) cycles.
REQ-020 SHALL, in DONE (one cycle), assert done=1 and busy=0, and set pass=1 only if no mismatch flag is set; the next state is IDLE.
REQ-021 SHALL hold pass and err_vec stable from DONE until the next accepted start.
REQ-022 SHALL accept start in the cycle after DONE, which allows back-to-back runs.
REQ-023 SHALL treat a y value of X or Z as a mismatch, since only an exact 0/1 match passes.

Reset
REQ-024 SHALL, while rst_n=0, immediately force: state IDLE, a=0, b=0, busy=0, done=0, pass=0, err_vec=0, index=0, settle counter=0.
REQ-025 SHALL abort a run in progress when rst_n asserts, producing no done pulse; a fresh start is required after release.

Configuration
REQ-026 SHALL use the macro GATE_CHECK_ERRLOG_EN.
REQ-027 SHALL, when GATE_CHECK_ERRLOG_EN is defined, drive err_vec from the registered per-vector mismatch flags.
REQ-028 SHALL, when GATE_CHECK_ERRLOG_EN is undefined, tie err_vec to 4'b0000, keep only a single sticky mismatch bit internally, and leave pass behaviour unchanged.

Verification
REQ-029 SHALL cover: SETTLE=2, correct NAND model, start pulse -> busy for 12 cycles, a/b sequence 00,01,10,11, done pulse, pass=1, err_vec=0000.
REQ-030 SHALL cover: y stuck at 1, macro defined -> pass=0, err_vec=1000; macro undefined -> pass=0, err_vec=0000.
REQ-031 SHALL cover: y stuck at 0 -> pass=0, err_vec=0111.
REQ-032 SHALL cover: start pulsed again while busy -> ignored, exactly one done pulse, run length unchanged.
REQ-033 SHALL cover: rst_n low during vector 2 -> all outputs 0 within the same cycle, no done pulse; a new start runs cleanly to pass=1.
REQ-034 SHALL cover: start held high continuously, SETTLE=1 -> done pulses every 10 cycles (8 busy, DONE, IDLE), pass=1 each time.
